// File: rtl/store_write_sequencer_if.sv
// Store-port / encoder / cache-write bundle for the store write sequencer.
// The master modport is the sequencer side; slave is the PC, encoder and cache side.
interface store_write_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] addr_PC;
   logic [31:0]       data_PC;
   logic [31:0]       enc_data;
   logic [15:0]       enc_parity;
   logic              cache_wr_en;
   logic [ADDR_W-1:0] cache_addr;
   logic [31:0]       data_Cache;
   logic [15:0]       parity_Cache;
   logic              cache_ack;
   logic              err_clr;
   logic              busy;
   logic              timeout_err;
   logic [7:0]        store_count;

   modport master (
      input  st_valid, addr_PC, data_PC, enc_parity, cache_ack, err_clr,
      output st_ready, enc_data, cache_wr_en, cache_addr, data_Cache, parity_Cache,
             busy, timeout_err, store_count
   );

   modport slave (
      output st_valid, addr_PC, data_PC, enc_parity, cache_ack, err_clr,
      input  st_ready, enc_data, cache_wr_en, cache_addr, data_Cache, parity_Cache,
             busy, timeout_err, store_count
   );
endinterface

// File: rtl/store_write_sequencer.sv
// Buffers PC stores, encodes the head entry and issues one acked cache write per store; first write 2 cycles after accept.
// Backpressure: st_ready drops while the buffer is full; a write held TIMEOUT cycles without ack is dropped.
module store_write_sequencer #(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   store_write_sequencer_if.master bus
);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ENCODE = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;

   logic [1:0]        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wr_en_q;
   logic [ADDR_W-1:0] cache_addr_q;
   logic [31:0]       data_q;
   logic [15:0]       parity_q;
   logic              timeout_err_q;
   logic [7:0]        store_count_q;

   logic push;
   logic ack_hit;
   logic tmo_hit;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Full is judged on the pre-pop count, so a full buffer never accepts in a pop cycle.
   assign bus.st_ready = (count < CNT_W'(DEPTH));
   assign push         = bus.st_valid && bus.st_ready;
   assign ack_hit      = (state == WRITE) && bus.cache_ack;
   assign tmo_hit      = (state == WRITE) && !bus.cache_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
   assign pop          = ack_hit || tmo_hit;
   assign count_nxt    = count + CNT_W'(push) - CNT_W'(pop);

   assign bus.enc_data     = (count != '0) ? data_mem[rd_ptr] : 32'd0;
   assign bus.cache_wr_en  = wr_en_q;
   assign bus.cache_addr   = cache_addr_q;
   assign bus.data_Cache   = data_q;
   assign bus.parity_Cache = parity_q;
   assign bus.busy         = (state != IDLE) || (count != '0);
   assign bus.timeout_err  = timeout_err_q;
   assign bus.store_count  = store_count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= bus.addr_PC;
         data_mem[wr_ptr] <= bus.data_PC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         wr_en_q       <= 1'b0;
         cache_addr_q  <= '0;
         data_q        <= '0;
         parity_q      <= '0;
         store_count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (count_nxt != '0) begin
                  state <= ENCODE;
               end
            end
            ENCODE: begin
               cache_addr_q <= addr_mem[rd_ptr];
               data_q       <= data_mem[rd_ptr];
               parity_q     <= bus.enc_parity;
               wr_en_q      <= 1'b1;
               wait_cnt     <= '0;
               state        <= WRITE;
            end
            WRITE: begin
               if (pop) begin
                  wr_en_q <= 1'b0;
                  state   <= (count_nxt != '0) ? ENCODE : IDLE;
                  if (ack_hit) begin
                     store_count_q <= store_count_q + 8'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A timeout in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_err_q <= 1'b0;
      end else if (tmo_hit) begin
         timeout_err_q <= 1'b1;
      end else if (bus.err_clr) begin
         timeout_err_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_store_write_sequencer.sv
// Directed bench for store_write_sequencer with a stand-in parity encoder and a cache-write monitor.
module tb_store_write_sequencer;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   store_write_sequencer_if #(.ADDR_W(10)) sif ();

   store_write_sequencer #(.ADDR_W(10), .DEPTH(2), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.master)
   );

   function automatic logic [15:0] enc_model(input logic [31:0] d);
      return d[31:16] ^ d[15:0] ^ {d[7:0], d[15:8]};
   endfunction

   assign sif.enc_parity = enc_model(sif.enc_data);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0]  mon_addr [$];
   logic [31:0] mon_data [$];
   logic [15:0] mon_par  [$];
   int          done_cnt = 0;

   always @(posedge clk) begin
      if (!rst && sif.cache_wr_en && sif.cache_ack) begin
         mon_addr.push_back(sif.cache_addr);
         mon_data.push_back(sif.data_Cache);
         mon_par.push_back(sif.parity_Cache);
         done_cnt = done_cnt + 1;
      end
   end

   int exp_count;

   task automatic drive_store(input logic [9:0] a, input logic [31:0] d);
      int n;
      sif.st_valid = 1'b1;
      sif.addr_PC  = a;
      sif.data_PC  = d;
      n = 0;
      while (!sif.st_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sif.st_ready) begin
         errors++;
         $display("FAIL drive_store_timeout st_ready=%0b required 1", sif.st_ready);
      end
      @(negedge clk);
      sif.st_valid = 1'b0;
   endtask

   task automatic wait_wr_en();
      int n;
      n = 0;
      while (!sif.cache_wr_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sif.cache_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL wait_wr_en cache_wr_en=%0b required 1", sif.cache_wr_en);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({sif.st_ready, sif.cache_wr_en, sif.busy, sif.timeout_err} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags ready/wr_en/busy/err=%b required 1000",
                  {sif.st_ready, sif.cache_wr_en, sif.busy, sif.timeout_err});
      end
      checks++;
      if (sif.store_count !== 8'd0 || sif.enc_data !== 32'd0 || sif.data_Cache !== 32'd0 ||
          sif.parity_Cache !== 16'd0 || sif.cache_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_values count=%0d enc=%h dc=%h pc=%h ca=%h required all 0",
                  sif.store_count, sif.enc_data, sif.data_Cache, sif.parity_Cache, sif.cache_addr);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      sif.st_valid = 1'b1;
      sif.addr_PC  = 10'h005;
      sif.data_PC  = 32'hDEADBEEF;
      @(negedge clk);
      sif.st_valid = 1'b0;
      checks++;
      if (sif.cache_wr_en !== 1'b0 || sif.busy !== 1'b1 || sif.enc_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_encode wr_en=%0b busy=%0b enc=%h required 0 1 deadbeef",
                  sif.cache_wr_en, sif.busy, sif.enc_data);
      end
      @(negedge clk);
      checks++;
      if (sif.cache_wr_en !== 1'b1 || sif.cache_addr !== 10'h005 || sif.data_Cache !== 32'hDEADBEEF ||
          sif.parity_Cache !== enc_model(32'hDEADBEEF)) begin
         errors++;
         $display("FAIL single_write wr_en=%0b addr=%h data=%h par=%h required 1 005 deadbeef %h",
                  sif.cache_wr_en, sif.cache_addr, sif.data_Cache, sif.parity_Cache,
                  enc_model(32'hDEADBEEF));
      end
      @(negedge clk);
      sif.cache_ack = 1'b1;
      @(negedge clk);
      sif.cache_ack = 1'b0;
      exp_count = exp_count + 1;
      checks++;
      if (sif.cache_wr_en !== 1'b0 || sif.store_count !== 8'(exp_count) || sif.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done wr_en=%0b count=%0d busy=%0b required 0 %0d 0",
                  sif.cache_wr_en, sif.store_count, sif.busy, exp_count);
      end
      checks++;
      if (sif.data_Cache !== 32'hDEADBEEF || sif.enc_data !== 32'd0) begin
         errors++;
         $display("FAIL single_hold data=%h enc=%h required deadbeef 00000000",
                  sif.data_Cache, sif.enc_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0]  ea [3];
      logic [31:0] ed [3];
      int base;
      int n;
      bit stayed_full;
      ea[0] = 10'h010; ed[0] = 32'h11112222;
      ea[1] = 10'h020; ed[1] = 32'h3333A5A5;
      ea[2] = 10'h030; ed[2] = 32'h0BADF00D;
      base = done_cnt;
      sif.cache_ack = 1'b0;
      sif.st_valid  = 1'b1;
      sif.addr_PC   = ea[0];
      sif.data_PC   = ed[0];
      @(negedge clk);
      sif.addr_PC = ea[1];
      sif.data_PC = ed[1];
      checks++;
      if (sif.st_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_one st_ready=%0b required 1", sif.st_ready);
      end
      @(negedge clk);
      sif.addr_PC = ea[2];
      sif.data_PC = ed[2];
      stayed_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (sif.st_ready !== 1'b0) stayed_full = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!stayed_full || sif.cache_wr_en !== 1'b1 || sif.cache_addr !== ea[0]) begin
         errors++;
         $display("FAIL b2b_full stayed_full=%0b wr_en=%0b addr=%h required 1 1 %h",
                  stayed_full, sif.cache_wr_en, sif.cache_addr, ea[0]);
      end
      sif.cache_ack = 1'b1;
      n = 0;
      while (!sif.st_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      sif.st_valid = 1'b0;
      n = 0;
      while (done_cnt < base + 3 && n < 40) begin
         @(negedge clk);
         n++;
      end
      sif.cache_ack = 1'b0;
      checks++;
      if (done_cnt - base !== 3) begin
         errors++;
         $display("FAIL b2b_writes count=%0d required 3", done_cnt - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_addr[base+i] !== ea[i] || mon_data[base+i] !== ed[i] ||
                mon_par[base+i] !== enc_model(ed[i])) begin
               errors++;
               $display("FAIL b2b_order_%0d addr=%h data=%h par=%h required %h %h %h", i,
                        mon_addr[base+i], mon_data[base+i], mon_par[base+i],
                        ea[i], ed[i], enc_model(ed[i]));
            end
         end
      end
      @(negedge clk);
      exp_count = exp_count + 3;
      checks++;
      if (sif.store_count !== 8'(exp_count) || sif.busy !== 1'b0 || sif.timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done count=%0d busy=%0b err=%0b required %0d 0 0",
                  sif.store_count, sif.busy, sif.timeout_err, exp_count);
      end
   endtask

   task automatic test_timeout();
      int n;
      int base;
      base = done_cnt;
      sif.cache_ack = 1'b0;
      drive_store(10'h3FF, 32'hCAFEF00D);
      wait_wr_en();
      n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!sif.cache_wr_en) break;
         n++;
      end
      checks++;
      if (n !== 15) begin
         errors++;
         $display("FAIL timeout_len high_cycles=%0d required 15", n);
      end
      checks++;
      if (sif.timeout_err !== 1'b1 || sif.store_count !== 8'(exp_count) ||
          sif.busy !== 1'b0 || done_cnt !== base) begin
         errors++;
         $display("FAIL timeout_drop err=%0b count=%0d busy=%0b acks=%0d required 1 %0d 0 0",
                  sif.timeout_err, sif.store_count, sif.busy, done_cnt - base, exp_count);
      end
      sif.err_clr = 1'b1;
      @(negedge clk);
      sif.err_clr = 1'b0;
      checks++;
      if (sif.timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear err=%0b required 0", sif.timeout_err);
      end
   endtask

   task automatic test_ack_at_limit();
      sif.cache_ack = 1'b0;
      drive_store(10'h2AA, 32'h0F0F1234);
      wait_wr_en();
      repeat (14) @(negedge clk);
      checks++;
      if (sif.cache_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL limit_still_high wr_en=%0b required 1", sif.cache_wr_en);
      end
      sif.cache_ack = 1'b1;
      @(negedge clk);
      sif.cache_ack = 1'b0;
      exp_count = exp_count + 1;
      checks++;
      if (sif.cache_wr_en !== 1'b0 || sif.timeout_err !== 1'b0 || sif.store_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL limit_ack wr_en=%0b err=%0b count=%0d required 0 0 %0d",
                  sif.cache_wr_en, sif.timeout_err, sif.store_count, exp_count);
      end
   endtask

   task automatic test_reset_mid_write();
      sif.cache_ack = 1'b0;
      sif.st_valid  = 1'b1;
      sif.addr_PC   = 10'h101;
      sif.data_PC   = 32'h55AA55AA;
      @(negedge clk);
      sif.addr_PC = 10'h102;
      sif.data_PC = 32'hAA55AA55;
      @(negedge clk);
      sif.st_valid = 1'b0;
      checks++;
      if (sif.cache_wr_en !== 1'b1 || sif.st_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_setup wr_en=%0b st_ready=%0b required 1 0", sif.cache_wr_en, sif.st_ready);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (sif.cache_wr_en !== 1'b0 || sif.st_ready !== 1'b1 || sif.busy !== 1'b0 || sif.store_count !== 8'd0) begin
         errors++;
         $display("FAIL midrst_async wr_en=%0b st_ready=%0b busy=%0b count=%0d required 0 1 0 0",
                  sif.cache_wr_en, sif.st_ready, sif.busy, sif.store_count);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (sif.busy !== 1'b0 || sif.cache_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_lost busy=%0b wr_en=%0b required 0 0", sif.busy, sif.cache_wr_en);
      end
   endtask

   task automatic test_wrap();
      int acc;
      int base;
      int n;
      base = done_cnt;
      acc  = 0;
      n    = 0;
      sif.cache_ack = 1'b1;
      sif.st_valid  = 1'b1;
      while (acc < 256 && n < 4000) begin
         sif.addr_PC = 10'(acc);
         sif.data_PC = 32'h01000000 * acc + 32'h1357;
         if (sif.st_ready) acc++;
         @(negedge clk);
         n++;
      end
      sif.st_valid = 1'b0;
      n = 0;
      while (sif.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sif.store_count !== 8'd0 || done_cnt - base !== 256 || sif.busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap count=%0d acks=%0d busy=%0b required 0 256 0",
                  sif.store_count, done_cnt - base, sif.busy);
      end
      repeat (3) @(negedge clk);
      sif.cache_ack = 1'b0;
      checks++;
      if (sif.store_count !== 8'd0 || sif.cache_wr_en !== 1'b0 || done_cnt - base !== 256) begin
         errors++;
         $display("FAIL stray_ack count=%0d wr_en=%0b acks=%0d required 0 0 256",
                  sif.store_count, sif.cache_wr_en, done_cnt - base);
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      exp_count     = 0;
      rst           = 1'b1;
      sif.st_valid  = 1'b0;
      sif.addr_PC   = '0;
      sif.data_PC   = '0;
      sif.cache_ack = 1'b0;
      sif.err_clr   = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_write();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
